// File: rtl/bnn_seq_pkg.sv
// Shared state encoding, default geometry and width helpers for the BNN batch sequencer.
package bnn_seq_pkg;

   localparam int DEF_FEAT_CNT  = 11;
   localparam int DEF_FEAT_BITS = 4;
   localparam int DEF_CLASS_CNT = 7;
   localparam int DEF_TEST_CNT  = 1000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_MEM,
      S_SETTLE,
      S_EMIT,
      S_DONE
   } state_t;

   // Width of a class label; never collapses to zero bits.
   function automatic int cw_of(input int class_cnt);
      return (class_cnt > 1) ? $clog2(class_cnt) : 1;
   endfunction

   // Width of a vector index; never collapses to zero bits.
   function automatic int aw_of(input int test_cnt);
      return (test_cnt > 1) ? $clog2(test_cnt) : 1;
   endfunction

endpackage

// File: rtl/bnn_seq_stats.sv
// Per-batch accumulation: count of correct classifications and sticky out-of-range flag.
module bnn_seq_stats #(
   parameter int AW = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clear,
   input  logic        i_sample,
   input  logic        i_range_bad,
   input  logic        i_accept,
   input  logic        i_hit,
   output logic [AW:0] o_correct_cnt,
   output logic        o_range_err
);

   logic [AW:0] r_correct_cnt;
   logic        r_range_err;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_correct_cnt <= '0;
         r_range_err   <= 1'b0;
      end else if (i_clear) begin
         r_correct_cnt <= '0;
         r_range_err   <= 1'b0;
      end else begin
         if (i_accept && i_hit)
            r_correct_cnt <= r_correct_cnt + (AW+1)'(1);
         if (i_sample && i_range_bad)
            r_range_err <= 1'b1;
      end
   end

   assign o_correct_cnt = r_correct_cnt;
   assign o_range_err   = r_range_err;

endmodule

// File: rtl/bnn_batch_sequencer.sv
// Walks a batch of test vectors through an external combinational classifier and streams scored results.
module bnn_batch_sequencer
   import bnn_seq_pkg::*;
#(
   parameter  int FEAT_CNT   = DEF_FEAT_CNT,
   parameter  int FEAT_BITS  = DEF_FEAT_BITS,
   parameter  int CLASS_CNT  = DEF_CLASS_CNT,
   parameter  int TEST_CNT   = DEF_TEST_CNT,
   parameter  int SETTLE_CYC = 2,
   localparam int CW         = cw_of(CLASS_CNT),
   localparam int AW         = aw_of(TEST_CNT),
   localparam int FW         = FEAT_CNT * FEAT_BITS
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [FW+CW-1:0] mem_data,
   output logic [FW-1:0] features,
   input  logic [CW-1:0] prediction,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_index,
   output logic [CW-1:0] out_class,
   output logic          out_hit,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   correct_cnt,
   output logic          range_err
);

   localparam logic [AW-1:0] LAST_IDX    = AW'(TEST_CNT - 1);
   localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYC);
   localparam logic [CW:0]   CLASS_LIM   = (CW+1)'(CLASS_CNT);

   state_t        r_state;
   logic [AW-1:0] r_idx;
   logic [3:0]    r_settle;
   logic [FW-1:0] r_features;
   logic [CW-1:0] r_label;
   logic          r_mem_rd;
   logic          r_out_valid;
   logic [CW-1:0] r_out_class;
   logic          r_out_hit;
   logic          r_busy;
   logic          r_done;

   logic w_abort;
   logic w_clear;
   logic w_sample;
   logic w_accept;
   logic w_range_bad;
   logic w_hit;

   // Abort only matters once a batch is running; in IDLE a simultaneous start wins.
   assign w_abort     = abort && (r_state != S_IDLE);
   assign w_clear     = (r_state == S_IDLE) && start;
   assign w_sample    = (r_state == S_SETTLE) && (r_settle == 4'd1) && !w_abort;
   assign w_accept    = (r_state == S_EMIT) && r_out_valid && out_ready && !w_abort;
   assign w_range_bad = ({1'b0, prediction} >= CLASS_LIM);
   assign w_hit       = (prediction == r_label) && !w_range_bad;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_settle    <= '0;
         r_features  <= '0;
         r_label     <= '0;
         r_mem_rd    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_class <= '0;
         r_out_hit   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_mem_rd <= 1'b0;
         r_done   <= 1'b0;
         if (w_abort) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_idx    <= '0;
                     r_mem_rd <= 1'b1;
                     r_busy   <= 1'b1;
                     r_state  <= S_FETCH;
                  end
               end
               S_FETCH: r_state <= S_WAIT_MEM;
               S_WAIT_MEM: begin
                  r_features <= mem_data[FW+CW-1:CW];
                  r_label    <= mem_data[CW-1:0];
                  r_settle   <= SETTLE_LOAD;
                  r_state    <= S_SETTLE;
               end
               S_SETTLE: begin
                  r_settle <= r_settle - 4'd1;
                  // Prediction is captured here so the EMIT payload cannot move under back-pressure.
                  if (r_settle == 4'd1) begin
                     r_out_valid <= 1'b1;
                     r_out_class <= prediction;
                     r_out_hit   <= w_hit;
                     r_state     <= S_EMIT;
                  end
               end
               S_EMIT: begin
                  if (out_ready) begin
                     r_out_valid <= 1'b0;
                     if (r_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end else begin
                        r_idx    <= r_idx + AW'(1);
                        r_mem_rd <= 1'b1;
                        r_state  <= S_FETCH;
                     end
                  end
               end
               S_DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   bnn_seq_stats #(.AW(AW)) u_stats (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_clear),
      .i_sample     (w_sample),
      .i_range_bad  (w_range_bad),
      .i_accept     (w_accept),
      .i_hit        (r_out_hit),
      .o_correct_cnt(correct_cnt),
      .o_range_err  (range_err)
   );

   assign mem_rd    = r_mem_rd;
   assign mem_addr  = r_idx;
   assign features  = r_features;
   assign out_valid = r_out_valid;
   assign out_index = r_idx;
   assign out_class = r_out_class;
   assign out_hit   = r_out_hit;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule
